// File: rtl/audio_framer.sv
// Overlapping-frame sample framer: buffers a PCM stream in a FRAME_LEN ring RAM
// and replays it as frames advancing by HOP_LEN samples, each tagged with out_num.
module audio_framer #(
    parameter int D_BW       = 14,
    parameter int FRAME_LEN  = 1024,
    parameter int HOP_LEN    = 512,
    parameter int TOTAL_DATA = 91136
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [D_BW-1:0]               s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [D_BW-1:0]               data_o,
    output logic [$clog2(TOTAL_DATA)-1:0] out_num,
    output logic                          do_en,
    output logic                          busy,
    output logic                          done
);
    localparam int AW         = $clog2(FRAME_LEN);
    localparam int CW         = AW + 1;
    localparam int NW         = $clog2(TOTAL_DATA);
    localparam int NUM_FRAMES = TOTAL_DATA / FRAME_LEN;
    localparam int FW         = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

    typedef enum logic [2:0] {IDLE, FILL, EMIT, REFILL, DONE} state_t;

    state_t          state;
    logic [AW-1:0]   wp;
    logic [AW-1:0]   rd_base;
    logic [AW-1:0]   rd_idx;
    logic [CW-1:0]   fill_cnt;
    logic [FW-1:0]   frame;

    logic            hs;
    logic [CW-1:0]   fill_last;
    logic [AW-1:0]   rd_addr;

    logic [D_BW-1:0] ram [FRAME_LEN];
    logic [D_BW-1:0] rd_data;
    logic            rd_vld;
    logic [NW-1:0]   rd_num;

    assign hs        = s_valid && s_ready;
    assign fill_last = (state == REFILL) ? CW'(HOP_LEN - 1) : CW'(FRAME_LEN - 1);
    // rd_base is the oldest sample, so the ring wraps naturally in AW bits.
    assign rd_addr   = rd_base + rd_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wp       <= '0;
            rd_base  <= '0;
            rd_idx   <= '0;
            fill_cnt <= '0;
            frame    <= '0;
            s_ready  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= FILL;
                        wp       <= '0;
                        frame    <= '0;
                        fill_cnt <= '0;
                        s_ready  <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                FILL, REFILL: begin
                    if (hs) begin
                        wp <= wp + AW'(1);
                        if (fill_cnt == fill_last) begin
                            fill_cnt <= '0;
                            rd_base  <= wp + AW'(1);
                            rd_idx   <= '0;
                            s_ready  <= 1'b0;
                            state    <= EMIT;
                        end else begin
                            fill_cnt <= fill_cnt + CW'(1);
                        end
                    end
                end
                EMIT: begin
                    rd_idx <= rd_idx + AW'(1);
                    if (rd_idx == AW'(FRAME_LEN - 1)) begin
                        if (frame == FW'(NUM_FRAMES - 1)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            // Last reads hit wp-2/wp-1, so refill writes at wp cannot collide.
                            frame   <= frame + FW'(1);
                            s_ready <= 1'b1;
                            state   <= REFILL;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the sample RAM has no reset; its contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (hs) ram[wp] <= s_data;
        rd_data <= ram[rd_addr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_vld  <= 1'b0;
            rd_num  <= '0;
            do_en   <= 1'b0;
            data_o  <= '0;
            out_num <= '0;
        end else begin
            rd_vld <= (state == EMIT);
            rd_num <= NW'({frame, rd_idx});
            do_en  <= rd_vld;
            if (rd_vld) begin
                data_o  <= rd_data;
                out_num <= rd_num;
            end
        end
    end
endmodule

// File: tb/tb_audio_framer.sv
// Directed bench for audio_framer at small parameters (FRAME_LEN=8, HOP_LEN=4, 3 frames):
// ramp, stalled input, ignored start pulses, back-to-back runs and mid-EMIT reset.
module tb_audio_framer;
    localparam int D_BW     = 14;
    localparam int FL       = 8;
    localparam int HOP      = 4;
    localparam int TOTAL    = 24;
    localparam int NF       = TOTAL / FL;
    localparam int TOTAL_IN = FL + (NF - 1) * HOP;
    localparam int NW       = $clog2(TOTAL);

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [D_BW-1:0] s_data;
    logic            s_valid;
    logic            s_ready;
    logic [D_BW-1:0] data_o;
    logic [NW-1:0]   out_num;
    logic            do_en;
    logic            busy;
    logic            done;

    int   checks     = 0;
    int   failures   = 0;
    int   cyc        = 0;
    int   in_cnt     = 0;
    int   exp_num    = 0;
    int   emit_cyc   = 0;
    bit   emit_armed = 1'b0;
    logic prev_do_en = 1'b0;
    logic [3:0] stall_pat = 4'b1001;

    audio_framer #(
        .D_BW(D_BW), .FRAME_LEN(FL), .HOP_LEN(HOP), .TOTAL_DATA(TOTAL)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .data_o(data_o), .out_num(out_num), .do_en(do_en),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Ramp input: output n of frame f, position i carries input sample f*HOP+i.
    function automatic logic [31:0] exp_data(input int n);
        int f;
        int i;
        f = n / FL;
        i = n % FL;
        return 32'((f * HOP + i) & ((1 << D_BW) - 1));
    endfunction

    task automatic tick(input bit stall, input bit inject);
        logic acc;
        int   d;
        acc = s_valid && s_ready;
        @(posedge clk);
        #1;
        cyc++;
        start = 1'b0;
        if (acc) begin
            in_cnt++;
            if (in_cnt == FL || (in_cnt > FL && (in_cnt - FL) % HOP == 0)) begin
                emit_cyc   = cyc;
                emit_armed = 1'b1;
            end
        end
        s_data  = D_BW'(in_cnt);
        s_valid = stall ? stall_pat[cyc[1:0]] : 1'b1;
        d = cyc - emit_cyc;
        if (emit_armed && d < FL) check("s_ready_emit", 32'(s_ready), 0);
        if (emit_armed && d == FL) begin
            check("s_ready_after_emit", 32'(s_ready), 32'(in_cnt < TOTAL_IN));
            check("busy_after_emit", 32'(busy), 32'(in_cnt < TOTAL_IN));
            check("done_after_emit", 32'(done), 32'(in_cnt == TOTAL_IN));
        end
        if (inject && emit_armed && d == 3) start = 1'b1;
        if (inject && s_ready && in_cnt == FL + 1) start = 1'b1;
        if (do_en) begin
            if (!prev_do_en && emit_armed) check("do_en_latency", 32'(d), 2);
            check("out_num", 32'(out_num), 32'(exp_num));
            check("data_o", 32'(data_o), exp_data(exp_num));
            exp_num++;
        end else if (prev_do_en) begin
            check("burst_len", 32'(exp_num % FL), 0);
        end
        prev_do_en = do_en;
    endtask

    task automatic run(input bit stall, input bit inject, input int abort_at);
        bit finished;
        finished   = 1'b0;
        in_cnt     = 0;
        exp_num    = 0;
        emit_armed = 1'b0;
        prev_do_en = 1'b0;
        start      = 1'b1;
        for (int n = 0; n < 400; n++) begin
            tick(stall, inject);
            if (abort_at >= 0 && exp_num == abort_at) begin
                finished = 1'b1;
                break;
            end
            if (done && !do_en) begin
                finished = 1'b1;
                break;
            end
        end
        check("run_terminated", 32'(finished), 1);
        if (abort_at < 0) begin
            check("samples_accepted", 32'(in_cnt), 32'(TOTAL_IN));
            check("outputs_emitted", 32'(exp_num), 32'(TOTAL));
            check("done_at_end", 32'(done), 1);
            check("busy_at_end", 32'(busy), 0);
            check("s_ready_at_end", 32'(s_ready), 0);
        end
    endtask

    initial begin
        rst     = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_ready", 32'(s_ready), 0);
        check("rst_do_en", 32'(do_en), 0);
        check("rst_data_o", 32'(data_o), 0);
        check("rst_out_num", 32'(out_num), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        @(negedge clk);
        rst = 1'b1;
        s_valid = 1'b1;
        repeat (3) tick(1'b0, 1'b0);
        check("idle_s_ready", 32'(s_ready), 0);
        check("idle_do_en", 32'(do_en), 0);
        check("idle_busy", 32'(busy), 0);

        run(1'b0, 1'b0, -1);
        run(1'b0, 1'b1, -1);
        run(1'b1, 1'b0, -1);

        run(1'b0, 1'b0, FL + 3);
        rst = 1'b0;
        #1;
        check("midrst_do_en", 32'(do_en), 0);
        check("midrst_s_ready", 32'(s_ready), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_out_num", 32'(out_num), 0);
        @(negedge clk);
        rst        = 1'b1;
        in_cnt     = 0;
        emit_armed = 1'b0;
        prev_do_en = 1'b0;
        repeat (4) tick(1'b0, 1'b0);
        check("postrst_do_en", 32'(do_en), 0);
        check("postrst_s_ready", 32'(s_ready), 0);
        check("postrst_busy", 32'(busy), 0);
        run(1'b0, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
